// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with hardwired zero register, clear sweep and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and mask pending) to matching read ports.

module regfile_sb_rport #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic              pend_rd,
  input  logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rpend
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic hit;
  assign hit = BYPASS && we && !busy && (waddr == raddr) && (waddr != ZR);

  always_comb begin
    rdata = mem_rd;
    if (raddr == ZR || busy) rdata = '0;
    else if (hit)            rdata = wdata;
  end

  // A forwarded result satisfies the reservation in the same cycle.
  assign rpend = pend_rd && !hit;
endmodule

module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rpend,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_acc, rsv_acc, clr_start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = done_q;
  end

  assign clr_start = (state_q == IDLE) && clr_req;
  assign wr_acc    = we && !clr_busy && (waddr != ZR);
  assign rsv_acc   = rsv_en && !clr_busy && (rsv_addr != ZR);

  // Storage is deliberately unreset; the sweep defines it.
  always_ff @(posedge clk) begin
    if (clr_busy)    mem[idx_q] <= '0;
    else if (wr_acc) mem[waddr] <= wdata;
  end

  // Reservation is applied after release so a same-address pair stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else if (clr_start) pending <= '0;
    else begin
      if (wr_acc)  pending[waddr]    <= 1'b0;
      if (rsv_acc) pending[rsv_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[i*ADDR_W +: ADDR_W];
    regfile_sb_rport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport (
      .raddr  (ra),
      .mem_rd (mem[ra]),
      .pend_rd(pending[ra]),
      .busy   (clr_busy),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[i*DATA_W +: DATA_W]),
      .rpend  (rpend[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_regfile_sb;
  localparam int DW = 8, AW = 5, NR = 2, ZR = 31, DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, we, rsv_en, clr_req;
  logic [AW-1:0] waddr, rsv_addr;
  logic [DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rpend;
  logic clr_busy, clr_done;

  int checks = 0, failures = 0;

  // Behavioural model
  logic [DW-1:0] m_mem [DEPTH];
  bit m_pend [DEPTH];
  bit m_busy, m_done;
  int m_idx;

  regfile_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == ZR || m_busy) return '0;
    if (BYP && we && int'(waddr) == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input int a);
    if (BYP && we && !m_busy && int'(waddr) == a && a != ZR) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    m_busy = 1'b1; m_done = 1'b0; m_idx = 0;
    foreach (m_pend[k]) m_pend[k] = 1'b0;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_done = (m_idx == DEPTH);
      if (m_done) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (we && int'(waddr) != ZR) begin
        m_mem[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (rsv_en && int'(rsv_addr) != ZR) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_busy = 1'b1; m_idx = 0;
        foreach (m_pend[k]) m_pend[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = '0; wdata = '0; rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  task automatic test_reset();
    int nb = 0, nd = 0, dc = -1;
    rst = 1; idle_inputs(); raddr = {5'd3, 5'd0};
    model_reset();
    #2;
    checks++; if (clr_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", clr_done); end
    checks++; if (rpend !== 2'b00) begin failures++; $display("FAIL reset_rpend got=%b want=00", rpend); end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
    step(); step();
    rst = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (clr_busy) nb++;
      if (clr_done) begin nd++; dc = c; end
      step();
    end
    checks++; if (nb != DEPTH) begin failures++; $display("FAIL sweep_len got=%0d want=%0d", nb, DEPTH); end
    checks++; if (nd != 1 || dc != DEPTH) begin failures++; $display("FAIL sweep_done count=%0d cycle=%0d want 1 at %0d", nd, dc, DEPTH); end
    for (int a = 0; a < DEPTH; a += 2) begin
      raddr = {AW'(a + 1), AW'(a)};
      #2;
      checks++;
      if (rdata !== 16'h0) begin failures++; $display("FAIL post_clear_read addr=%0d got=%h want=0000", a, rdata); end
      step();
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] want;
    idle_inputs();
    we = 1; waddr = 5'd3; wdata = 8'hA5; raddr = {5'd3, 5'd3};
    want = BYP ? 8'hA5 : 8'h00;
    #2;
    checks++; if (rdata[7:0] !== want || rdata[15:8] !== want) begin failures++; $display("FAIL write_cycle_read got=%h want=%h", rdata, want); end
    step();
    we = 0;
    #2;
    checks++; if (rdata !== 16'hA5A5) begin failures++; $display("FAIL read_after_write got=%h want=a5a5", rdata); end
    step();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we = 1; waddr = 5'd31; wdata = 8'hFF; raddr = {5'd31, 5'd31};
    step();
    we = 0;
    #2;
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL zero_reg_read got=%h want=0000", rdata); end
    rsv_en = 1; rsv_addr = 5'd31;
    step();
    rsv_en = 0;
    #2;
    checks++; if (rpend !== 2'b00) begin failures++; $display("FAIL zero_reg_pend got=%b want=00", rpend); end
    step();
  endtask

  task automatic test_scoreboard();
    logic want;
    idle_inputs();
    raddr = {5'd7, 5'd7};
    rsv_en = 1; rsv_addr = 5'd7;
    step();
    rsv_en = 0;
    #2;
    checks++; if (rpend !== 2'b11) begin failures++; $display("FAIL rsv_visible got=%b want=11", rpend); end
    we = 1; waddr = 5'd7; wdata = 8'h12;
    want = !BYP;
    #2;
    checks++; if (rpend !== {want, want}) begin failures++; $display("FAIL pend_write_cycle got=%b want=%b%b", rpend, want, want); end
    step();
    we = 0;
    #2;
    checks++; if (rpend !== 2'b00 || rdata !== 16'h1212) begin failures++; $display("FAIL pend_released got=%b/%h want=00/1212", rpend, rdata); end
    we = 1; waddr = 5'd7; wdata = 8'h34; rsv_en = 1; rsv_addr = 5'd7;
    step();
    we = 0; rsv_en = 0;
    #2;
    checks++; if (rpend !== 2'b11 || rdata !== 16'h3434) begin failures++; $display("FAIL rsv_wins got=%b/%h want=11/3434", rpend, rdata); end
    step();
  endtask

  task automatic test_clear();
    int nb = 0, nd = 0, dc = -1;
    idle_inputs();
    raddr = {5'd5, 5'd5};
    we = 1; waddr = 5'd5; wdata = 8'h3C;
    step();
    we = 0; clr_req = 1;
    #2;
    checks++; if (rdata !== 16'h3C3C) begin failures++; $display("FAIL pre_clear_read got=%h want=3c3c", rdata); end
    step();
    for (int c = 0; c < 40; c++) begin
      we = (c == 2); waddr = 5'd5; wdata = 8'h77;
      clr_req = (c == 5);
      #2;
      if (clr_busy) begin
        nb++;
        if (c == 2 || c == 20) begin
          checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL sweep_rdata cycle=%0d got=%h want=0000", c, rdata); end
        end
      end
      if (clr_done) begin nd++; dc = c; end
      step();
    end
    idle_inputs();
    #2;
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL r5_after_clear got=%h want=0000", rdata); end
    checks++; if (nb != DEPTH) begin failures++; $display("FAIL clear_len got=%0d want=%0d", nb, DEPTH); end
    checks++; if (nd != 1 || dc != DEPTH) begin failures++; $display("FAIL clear_done count=%0d cycle=%0d want 1 at %0d", nd, dc, DEPTH); end
    step();
  endtask

  task automatic test_reset_midsweep();
    int nb = 0, nd = 0, dc = -1;
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    for (int k = 0; k < 10; k++) step();
    rst = 1; model_reset();
    #2;
    checks++; if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin failures++; $display("FAIL midsweep_reset got=%b%b want=10", clr_busy, clr_done); end
    step();
    rst = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (clr_busy) nb++;
      if (clr_done) begin nd++; dc = c; end
      step();
    end
    checks++; if (nb != DEPTH) begin failures++; $display("FAIL restart_len got=%0d want=%0d", nb, DEPTH); end
    checks++; if (nd != 1 || dc != DEPTH) begin failures++; $display("FAIL restart_done count=%0d cycle=%0d want 1 at %0d", nd, dc, DEPTH); end
  endtask

  task automatic test_random();
    int a;
    for (int c = 0; c < 600; c++) begin
      we       = ($urandom_range(0, 2) != 0);
      waddr    = ($urandom_range(0, 9) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
      wdata    = DW'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 9) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
      clr_req  = ($urandom_range(0, 99) == 0);
      raddr    = {AW'($urandom_range(0, 7)), (($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 7)))};
      if ($urandom_range(0, 15) == 0) raddr[AW-1:0] = 5'd31;
      #2;
      for (int p = 0; p < NR; p++) begin
        a = int'(raddr[p*AW +: AW]);
        checks++;
        if (rdata[p*DW +: DW] !== exp_rd(a)) begin failures++; $display("FAIL rand_rdata c=%0d port=%0d addr=%0d got=%h want=%h", c, p, a, rdata[p*DW +: DW], exp_rd(a)); end
        checks++;
        if (rpend[p] !== exp_pend(a)) begin failures++; $display("FAIL rand_rpend c=%0d port=%0d addr=%0d got=%b want=%b", c, p, a, rpend[p], exp_pend(a)); end
      end
      checks++;
      if (clr_busy !== m_busy || clr_done !== m_done) begin failures++; $display("FAIL rand_ctrl c=%0d got=%b%b want=%b%b", c, clr_busy, clr_done, m_busy, m_done); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_clear();
    test_reset_midsweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a hardwired zero register, an optional write-to-read bypass, a hardware clear sequencer and a pending-write scoreboard. It sits in the decode/writeback path of the 8-bit core. It generalises the fixed 2-read, 32×8 register file to configurable width, depth and read-port count. The scoreboard lets the hazard unit stall on registers whose results are still in flight.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports
- ZERO_REG, 31, index hardwired to read 0; must be < DEPTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NREAD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rpend  out  NREAD  port i's register has an outstanding reservation
- rsv_en  in  1  reserve a destination register (mark pending)
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  request a full clear of all registers
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when a sweep completes

## Operation
- Storage: DEPTH × DATA_W array, not reset directly; contents are defined only after a clear sweep.
- Read (combinational), per port i:
  - raddr_i == ZERO_REG → 0.
  - clr_busy → 0.
  - Bypass hit (see Configuration) → wdata.
  - Otherwise → array[raddr_i].
- Write: on posedge with we=1, clr_busy=0 and waddr != ZERO_REG, array[waddr] ← wdata. Writes to ZERO_REG are dropped.
- Scoreboard: DEPTH-bit pending vector.
  - rsv_en sets pending[rsv_addr].
  - An accepted write clears pending[waddr].
  - Reservation and write to the same address in the same cycle → pending ends set (the new reservation wins).
  - ZERO_REG is never pending. rsv_en is ignored while clr_busy.
- rpend_i = pending[raddr_i], masked per Configuration.
- Clear FSM, states IDLE and CLEAR, with an ADDR_W-bit index counter:
  - Reset → CLEAR, index 0, pending all 0.
  - CLEAR: each cycle array[index] ← 0 and index increments. When index == DEPTH-1, next state is IDLE and clr_done pulses.
  - IDLE + clr_req → CLEAR, index 0, pending vector cleared at the same edge.
  - clr_req while in CLEAR is ignored; the sweep is neither restarted nor extended.
  - we during CLEAR is dropped.
- Reset mid-sweep restarts the sweep from index 0.

## Timing
- Reset values: clr_busy=1, clr_done=0, rpend=0, rdata=0 (because clr_busy=1).
- Sweep length: exactly DEPTH cycles in CLEAR.
  - clr_busy is high for those DEPTH cycles.
  - clr_done is high in the cycle following the last index write, coincident with clr_busy falling.
  - After reset release, the first write is accepted on edge DEPTH+1.
- clr_req is sampled at a posedge in IDLE; clr_busy rises after that edge.
- Write latency: data is readable from the array one cycle after the write edge. With bypass enabled it is also visible combinationally in the write cycle.
- Scoreboard latency: a reservation is visible on rpend the cycle after rsv_en. Release follows Configuration.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Port i returns wdata when we && waddr == raddr_i && waddr != ZERO_REG && !clr_busy.
  - rpend_i is forced 0 on that same condition, so the consumer need not stall.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; rdata shows the old array value during the write cycle.
  - rpend_i stays high until the edge after the write.

## Test plan
- Reset, then hold for 32 cycles (defaults) → clr_busy high for exactly 32 cycles; clr_done pulses once at cycle 32; reading every address afterwards returns 0x00.
- Write 0xA5 to r3, then read r3 on both ports next cycle → 0xA5 on both. With bypass: read r3 in the write cycle → 0xA5, without bypass → 0x00.
- Write 0xFF to r31, then read r31 → 0x00. rsv_en on r31 → rpend stays 0.
- rsv_en r7 → rpend=1 when reading r7 the next cycle. Write r7=0x12 → rpend=0 in the write cycle with bypass, or the cycle after without it. Reserve and write r7 together → rpend remains 1.
- Write r5=0x3C, pulse clr_req, issue we r5=0x77 at sweep cycle 2 → write dropped; rdata 0 during the sweep; r5 reads 0x00 after clr_done; a second clr_req mid-sweep does not lengthen it past 32 cycles.
- Assert rst at sweep index 10 → the sweep restarts; clr_done arrives 32 cycles after rst release, with no earlier pulse.
